regfile_mp: RTL and testbench

Parametrised multi-read-port general-purpose register file for the pipelined MIPS datapath, succeeding the single-cycle CPU's fixed 32x32 two-read-port file. It adds configurable width, depth and read-port count, byte-enable writes, optional same-cycle write-to-read bypass, and a per-register pending scoreboard for hazard detection. It sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with byte enables, bypass and pending scoreboard
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM        = 32,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             RegWrite,
  input  logic [ADDR_WIDTH-1:0]            writeReg,
  input  logic [WIDTH-1:0]                 writeData,
  input  logic [WIDTH/8-1:0]               writeBE,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] readReg,
  output logic [READ_PORTS*WIDTH-1:0]      readData,
  output logic [READ_PORTS-1:0]            readPend,
  input  logic                             setPend,
  input  logic [ADDR_WIDTH-1:0]            setAddr
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] NUM_L = (ADDR_WIDTH+1)'(NUM);

  logic [WIDTH-1:0] regs [NUM];
  logic [NUM-1:0]   pend;
  logic             wrValid;
  logic             setValid;

  // Out-of-range addresses and the hardwired zero register behave as a constant-zero, never-pending slot.
  function automatic logic addrOk(input logic [ADDR_WIDTH-1:0] a);
    addrOk = ({1'b0, a} < NUM_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] mergeBytes(input logic [WIDTH-1:0] oldVal,
                                                  input logic [WIDTH-1:0] newVal,
                                                  input logic [NB-1:0]    be);
    mergeBytes = oldVal;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) mergeBytes[b*8 +: 8] = newVal[b*8 +: 8];
    end
  endfunction

  assign wrValid  = RegWrite && addrOk(writeReg);
  assign setValid = setPend && addrOk(setAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (wrValid && (writeReg == ADDR_WIDTH'(i))) regs[i] <= mergeBytes(regs[i], writeData, writeBE);
      end
    end
  end

  // A new producer issued on the same edge as a writeback keeps the register pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (setValid && (setAddr == ADDR_WIDTH'(i))) pend[i] <= 1'b1;
        else if (wrValid && (writeReg == ADDR_WIDTH'(i))) pend[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : gRead
    logic [ADDR_WIDTH-1:0] rAddr;
    logic [WIDTH-1:0]      rStored;
    logic                  rPend;
    logic                  rHit;
    logic                  rOk;

    assign rAddr = readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rOk   = addrOk(rAddr);
    assign rHit  = (BYPASS != 0) && wrValid && (writeReg == rAddr);

    always_comb begin
      rStored = '0;
      rPend   = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        if (rAddr == ADDR_WIDTH'(i)) begin
          rStored = regs[i];
          rPend   = pend[i];
        end
      end
    end

    assign readData[k*WIDTH +: WIDTH] = !rOk ? '0 :
                                        rHit ? mergeBytes(rStored, writeData, writeBE) : rStored;
    assign readPend[k] = rOk && !rHit && rPend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (bypass/4-port and no-bypass/16-entry builds)
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic         RegWrite;
  logic [4:0]   writeReg;
  logic [31:0]  writeData;
  logic [3:0]   writeBE;
  logic         setPend;
  logic [4:0]   setAddr;
  logic [19:0]  rdA;
  logic [9:0]   rdB;
  logic [127:0] dataA;
  logic [3:0]   pendA;
  logic [63:0]  dataB;
  logic [1:0]   pendB;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .ADDR_WIDTH(5), .NUM(32), .READ_PORTS(4), .BYPASS(1), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .writeBE(writeBE), .readReg(rdA), .readData(dataA), .readPend(pendA),
    .setPend(setPend), .setAddr(setAddr)
  );

  regfile_mp #(.WIDTH(32), .ADDR_WIDTH(5), .NUM(16), .READ_PORTS(2), .BYPASS(0), .ZERO_REG(1)) dutB (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .writeBE(writeBE), .readReg(rdB), .readData(dataB), .readPend(pendB),
    .setPend(setPend), .setAddr(setAddr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] aData(input int k);
    aData = dataA[k*32 +: 32];
  endfunction

  function automatic logic [31:0] bData(input int k);
    bData = dataB[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    setPend  = 1'b0;
    rst      = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    RegWrite  = 1'b1;
    writeReg  = a;
    writeData = d;
    writeBE   = be;
    #1;
  endtask

  task automatic setRd(input logic [4:0] a0, a1, a2, a3, b0, b1);
    rdA = {a3, a2, a1, a0};
    rdB = {b1, b0};
    #1;
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; writeReg = '0; writeData = '0; writeBE = '0;
    setPend = 1'b0; setAddr = '0; rdA = '0; rdB = '0;
    step();

    // reset state
    setRd(5, 6, 5, 6, 5, 6);
    checkVal("rst dataA r5", aData(0), 32'h0);
    checkVal("rst dataB r5", bData(0), 32'h0);
    checkVal("rst pendA", {28'h0, pendA}, 32'h0);

    // reset dominates concurrent write and set
    wr(5, 32'hDEADBEEF, 4'hF); setPend = 1'b1; setAddr = 6; step();
    checkVal("pre-rst r5", aData(0), 32'hDEADBEEF);
    checkVal("pre-rst pend r6", {31'h0, pendA[1]}, 32'h1);
    rst = 1'b1; wr(5, 32'h1, 4'hF); setPend = 1'b1; setAddr = 6; step();
    checkVal("post-rst dataA r5", aData(0), 32'h0);
    checkVal("post-rst dataB r5", bData(0), 32'h0);
    checkVal("post-rst pendA", {28'h0, pendA}, 32'h0);
    checkVal("post-rst pendB", {30'h0, pendB}, 32'h0);

    // byte enables
    setRd(3, 3, 3, 3, 3, 3);
    wr(3, 32'h11223344, 4'hF); step();
    wr(3, 32'hAABBCCDD, 4'b0101); step();
    checkVal("be dataA r3", aData(0), 32'h11BB33DD);
    checkVal("be dataB r3", bData(0), 32'h11BB33DD);
    wr(3, 32'hEE000000, 4'b1000);
    checkVal("be bypass A", aData(0), 32'hEEBB33DD);
    checkVal("be nobypass B", bData(0), 32'h11BB33DD);
    step();
    checkVal("be after B", bData(0), 32'hEEBB33DD);

    // write-to-read bypass
    setRd(0, 7, 0, 0, 0, 7);
    checkVal("byp before A", aData(1), 32'h0);
    wr(7, 32'h12345678, 4'hF);
    checkVal("byp same A", aData(1), 32'h12345678);
    checkVal("byp same B", bData(1), 32'h0);
    step();
    checkVal("byp next A", aData(1), 32'h12345678);
    checkVal("byp next B", bData(1), 32'h12345678);

    // hardwired zero register
    setRd(0, 0, 0, 0, 0, 0);
    wr(0, 32'hFFFFFFFF, 4'hF); setPend = 1'b1; setAddr = 0; #1;
    checkVal("zero same A", aData(0), 32'h0);
    checkVal("zero same B", bData(0), 32'h0);
    step();
    checkVal("zero next A", aData(0), 32'h0);
    checkVal("zero next B", bData(0), 32'h0);
    checkVal("zero pendA", {31'h0, pendA[0]}, 32'h0);

    // out of range on the 16-entry build
    setRd(20, 20, 20, 20, 20, 4);
    wr(20, 32'hFFFFFFFF, 4'hF);
    checkVal("oor same B", bData(0), 32'h0);
    step();
    checkVal("oor A r20", aData(0), 32'hFFFFFFFF);
    checkVal("oor B r20", bData(0), 32'h0);
    checkVal("oor B r4 alias", bData(1), 32'h0);
    setPend = 1'b1; setAddr = 20; step();
    checkVal("oor pendB r20", {31'h0, pendB[0]}, 32'h0);
    checkVal("oor pendA r20", {31'h0, pendA[0]}, 32'h1);

    // scoreboard
    setRd(9, 9, 9, 9, 9, 9);
    setPend = 1'b1; setAddr = 9; #1;
    checkVal("sb before edge", {28'h0, pendA}, 32'h0);
    step();
    checkVal("sb set A", {28'h0, pendA}, 32'hF);
    checkVal("sb set B", {30'h0, pendB}, 32'h3);
    wr(9, 32'h00000099, 4'hF);
    checkVal("sb clr same A", {28'h0, pendA}, 32'h0);
    checkVal("sb clr same B", {30'h0, pendB}, 32'h3);
    step();
    checkVal("sb clr next A", {28'h0, pendA}, 32'h0);
    checkVal("sb clr next B", {30'h0, pendB}, 32'h0);
    wr(9, 32'h00000055, 4'hF); setPend = 1'b1; setAddr = 9; #1;
    checkVal("sb both same A", {28'h0, pendA}, 32'h0);
    step();
    checkVal("sb both data A", aData(0), 32'h55);
    checkVal("sb both data B", bData(0), 32'h55);
    checkVal("sb both pend A", {28'h0, pendA}, 32'hF);
    checkVal("sb both pend B", {30'h0, pendB}, 32'h3);
    wr(9, 32'hFFFFFFFF, 4'h0); step();
    checkVal("sb be0 data", aData(0), 32'h55);
    checkVal("sb be0 pend", {28'h0, pendA}, 32'h0);

    // all ports on one register
    setRd(2, 2, 2, 2, 2, 2);
    for (int k = 0; k < 4; k++) checkVal($sformatf("mp before p%0d", k), aData(k), 32'h0);
    wr(2, 32'hCAFEF00D, 4'hF);
    for (int k = 0; k < 4; k++) checkVal($sformatf("mp same p%0d", k), aData(k), 32'hCAFEF00D);
    checkVal("mp same B", bData(0), 32'h0);
    step();
    for (int k = 0; k < 4; k++) checkVal($sformatf("mp next p%0d", k), aData(k), 32'hCAFEF00D);
    checkVal("mp next B0", bData(0), 32'hCAFEF00D);
    checkVal("mp next B1", bData(1), 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
